// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer slice.
//   fsm_state_e      : FETCH / HALTED state encoding
//   OPC_MSB/OPC_LSB  : opcode field position inside an instruction word
//   HALT_OPC_DEFAULT : default opcode that marks a halt instruction
//   wrap_addr()      : reduce an address modulo the instruction memory depth
//   opcode()         : extract the opcode field from an instruction word
package fetch_sequencer_pkg;

  typedef enum logic {
    ST_FETCH  = 1'b0,
    ST_HALTED = 1'b1
  } fsm_state_e;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  localparam logic [3:0] HALT_OPC_DEFAULT = 4'hF;

  function automatic logic [15:0] wrap_addr(input logic [15:0] addr,
                                            input int unsigned words);
    wrap_addr = 16'(32'(addr) % words);
  endfunction

  function automatic logic [3:0] opcode(input logic [15:0] ins);
    opcode = ins[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_sequencer_buffer.sv
// fetch_buffer: 2-entry FIFO holding {pc, ins} pairs.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write an entry (accepted when not full, or full with a pop)
//   pop        : drop the head entry (ignored when empty)
//   flush      : empty the FIFO; takes priority over push and pop
//   full/empty : occupancy flags
//   rdata      : head entry, forced to zero while empty
module fetch_buffer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] rdata
);

  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign do_pop  = pop && !empty;
  // When full, the write slot equals the head slot, so a push is only
  // legal if the head is leaving in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: drives a combinational-read instruction memory and
// buffers fetched {pc, ins} pairs in a 2-entry FIFO for a consumer.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   pc / ins                    : fetch address out, instruction word back
//   redirect_valid/redirect_pc  : flush and refetch from a new address
//   out_valid/out_ready         : consumer handshake
//   out_ins/out_pc              : head-of-buffer instruction and its address
//   halted                      : FSM is in HALTED
//   fetch_count                 : saturating count of accepted instructions
//   state                       : current FSM state (debug visibility)
//
// Handshake: an instruction transfers on a rising edge where out_valid and
// out_ready are both high; out_valid never depends on out_ready, and
// out_ins/out_pc hold steady while out_valid is high and out_ready is low.
// A redirect cancels any transfer in its cycle.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int unsigned IMEM_WORDS = 1024,
  parameter logic [3:0]  HALT_OPC   = HALT_OPC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] pc,
  input  logic [15:0] ins,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_ins,
  output logic [15:0] out_pc,
  output logic        halted,
  output logic [15:0] fetch_count,
  output fsm_state_e  state
);

  localparam logic [15:0] RESET_PC_W = wrap_addr(RESET_PC, IMEM_WORDS);
  localparam logic [15:0] LAST_PC    = 16'(IMEM_WORDS - 1);

  fsm_state_e  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] count_q;
  logic        push, pop, flush;
  logic        buf_full, buf_empty;
  logic [31:0] buf_rdata;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC_W;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state / control
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      flush   = 1'b1;
      pc_d    = wrap_addr(redirect_pc, IMEM_WORDS);
      state_d = ST_FETCH;
    end else begin
      pop = !buf_empty && out_ready;
      if (state_q == ST_FETCH && (!buf_full || pop)) begin
        push = 1'b1;
        if (opcode(ins) == HALT_OPC) begin
          // Halt word is buffered but pc parks on it.
          state_d = ST_HALTED;
        end else begin
          pc_d = (pc_q == LAST_PC) ? 16'h0000 : pc_q + 16'h0001;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 16'h0000;
    end else if (pop && count_q != 16'hFFFF) begin
      count_q <= count_q + 16'h0001;
    end
  end

  fetch_buffer #(.W(32)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({pc_q, ins}),
    .full  (buf_full),
    .empty (buf_empty),
    .rdata (buf_rdata)
  );

  assign pc          = pc_q;
  assign out_valid   = !buf_empty;
  assign out_pc      = buf_rdata[31:16];
  assign out_ins     = buf_rdata[15:0];
  assign halted      = (state_q == ST_HALTED);
  assign fetch_count = count_q;
  assign state       = state_q;

endmodule
